alu_muldiv_sequencer: RTL and testbench
=======================================

Name: alu_muldiv_sequencer

Overview:
Multi-cycle controller that implements unsigned MULTU and DIVU by sequencing the shared 32-bit arithmetic unit (add/sub/slt) one iteration per clock.
- Sits beside the arithmetic unit in the execute stage.
- Drives the unit's A, B and aluOp inputs and consumes its Result.
- Produces HI/LO for the register file's HI/LO registers, with a start/busy/done handshake to the control unit.

Parameters:
- WIDTH, 32, operand width; hi/lo are WIDTH each.
- CNT_W, 5, iteration counter width (log2 WIDTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- op  in  1  0 = MULTU, 1 = DIVU; sampled with start.
- src_a  in  WIDTH  multiplicand / dividend.
- src_b  in  WIDTH  multiplier / divisor.
- busy  out  1  high in MUL, DIV and DONE.
- done  out  1  one-cycle pulse, high in DONE.
- div_zero  out  1  set on DIVU with src_b == 0; held until next accepted start.
- hi  out  WIDTH  product high / remainder.
- lo  out  WIDTH  product low / quotient.
- alu_a  out  WIDTH  to arithmetic unit A.
- alu_b  out  WIDTH  to arithmetic unit B.
- alu_op  out  4  to arithmetic unit aluOp.
- alu_result  in  WIDTH  from arithmetic unit Result (combinational, same cycle).

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is synchronous and active-low.
- Reset values: state = IDLE, counter = 0, busy = 0, done = 0, div_zero = 0, hi = 0, lo = 0, alu_a = 0, alu_b = 0, alu_op = 4'b0000.
- Reset mid-operation: the next edge with rst_n = 0 aborts and applies the reset values; no done pulse is produced.
- States:
  - IDLE: on start, latch operands and go to MUL (op = 0) or DIV (op = 1 and src_b != 0).
  - IDLE, DIVU with src_b == 0: go directly to DONE with hi = src_a, lo = 32'hFFFF_FFFF, div_zero = 1.
  - MUL / DIV: 32 iterations, counter 0..31. Leave to DONE on the edge where counter == 31.
  - DONE: done = 1 for exactly one cycle, then IDLE.
- start while busy is ignored. No queuing and no effect on the current operation.
- Latency: start accepted at edge E0. First iteration executes in the cycle after E0. done is high in cycle 33 after E0 (counting E0 as 0). Divide-by-zero: done in cycle 1.
- hi/lo hold their final value from DONE until the next accepted start. Contents during MUL/DIV are working registers, and only valid when done is high or afterwards.
- MULTU (shift-add). Registers: P_hi = 0, P_lo = src_b, M = src_a.
  - Each cycle: alu_a = P_hi, alu_b = M, alu_op = ADD (4'b0000).
  - Carry is computed internally: c = (alu_result < P_hi), unsigned.
  - If P_lo[0] = 1: {P_hi, P_lo} <= {c, alu_result, P_lo} >> 1. Otherwise {P_hi, P_lo} <= {1'b0, P_hi, P_lo} >> 1.
  - Result: hi = P_hi, lo = P_lo.
- DIVU (restoring). Registers: R = 0, Q = src_a, D = src_b.
  - Each cycle: Rs = {R[30:0], Q[31]}, msb = R[31]; alu_a = Rs, alu_b = D, alu_op = SUB (4'b0010).
  - ge = msb | (Rs >= D), unsigned.
  - If ge: R <= alu_result, Q <= {Q[30:0], 1}. Otherwise R <= Rs, Q <= {Q[30:0], 0}.
  - Result: hi = R, lo = Q.
- In IDLE and DONE: alu_a = alu_b = 0, alu_op = ADD. The arithmetic unit is free for other users only when busy = 0; that muxing belongs to the parent.
- All arithmetic is modulo 2^WIDTH. SLT (4'b1010) is defined in the package but not issued.

Decomposition:
- Shared package `alu_pkg` holds:
  - ALU op constants ALU_ADD = 4'b0000, ALU_SUB = 4'b0010, ALU_SLT = 4'b1010.
  - Muldiv op constants OP_MULTU = 0, OP_DIVU = 1.
  - State encoding IDLE, MUL, DIV, DONE.
- No sub-module. The arithmetic unit is instantiated in the parent and reached through the alu_* ports.

Test Plan:
- MULTU 6 × 7 → done in cycle 33; hi = 0, lo = 42; busy high cycles 1–33.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001. Exercises the carry path.
- DIVU 100 / 7 → lo = 14, hi = 2, div_zero = 0. Also DIVU 0x80000000 / 3 → lo = 0x2AAAAAAA, hi = 2.
- DIVU 5 / 0 → done in cycle 1; hi = 5, lo = 0xFFFFFFFF, div_zero = 1. A following MULTU 2 × 3 clears div_zero, giving lo = 6.
- start re-asserted with different operands in cycles 5 and 20 of a MULTU 6 × 7 → ignored; result still 42; exactly one done pulse.
- rst_n low for one cycle at cycle 10 of a DIVU → all outputs return to reset values next cycle; no done pulse. A new DIVU 9 / 2 then gives lo = 4, hi = 1.
- Throughout all runs: alu_op = 0000 in every MUL cycle and 0010 in every DIV cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the arithmetic unit and the MULTU/DIVU sequencer.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_SLT = 4'b1010;

  localparam logic OP_MULTU = 1'b0;
  localparam logic OP_DIVU  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/alu_muldiv_sequencer.sv
// Multi-cycle unsigned MULTU/DIVU built on the shared add/sub unit, one iteration per clock.
//
// state | meaning
// IDLE  | waiting for start; arithmetic unit released (busy = 0)
// MUL   | shift-add multiply, 32 iterations
// DIV   | restoring divide, 32 iterations
// DONE  | one-cycle done pulse, hi/lo final
module alu_muldiv_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   rs;
  logic               ge;
  logic               carry;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    dz_d    = dz_q;
    alu_a   = '0;
    alu_b   = '0;
    alu_op  = ALU_ADD;
    // hi/lo double as P_hi/P_lo (multiply) and R/Q (divide); opnd holds M or D.
    rs      = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
    ge      = hi_q[WIDTH-1] | (rs >= opnd_q);
    carry   = (alu_result < hi_q);
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d = '0;
          dz_d  = 1'b0;
          if (op == OP_DIVU && src_b == '0) begin
            hi_d    = src_a;
            lo_d    = '1;
            dz_d    = 1'b1;
            state_d = DONE;
          end else if (op == OP_DIVU) begin
            hi_d    = '0;
            lo_d    = src_a;
            opnd_d  = src_b;
            state_d = DIV;
          end else begin
            hi_d    = '0;
            lo_d    = src_b;
            opnd_d  = src_a;
            state_d = MUL;
          end
        end
      end
      MUL: begin
        alu_a = hi_q;
        alu_b = opnd_q;
        if (lo_q[0]) {hi_d, lo_d} = {carry, alu_result, lo_q[WIDTH-1:1]};
        else         {hi_d, lo_d} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == '1) state_d = DONE;
      end
      DIV: begin
        alu_a  = rs;
        alu_b  = opnd_q;
        alu_op = ALU_SUB;
        hi_d   = ge ? alu_result : rs;
        lo_d   = {lo_q[WIDTH-2:0], ge};
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == '1) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Bench for alu_muldiv_sequencer with a behavioural arithmetic unit and a result scoreboard.
module tb_alu_muldiv_sequencer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo, alu_a, alu_b, alu_result;
  logic [3:0]  alu_op;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] cur_alu_op = ALU_ADD;

  always #5 clk = ~clk;

  assign alu_result = (alu_op == ALU_SUB) ? alu_a - alu_b :
                      (alu_op == ALU_SLT) ? {31'b0, $signed(alu_a) < $signed(alu_b)} :
                      alu_a + alu_b;

  alu_muldiv_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result)
  );

  // Arithmetic-unit drive: iteration op while working, released (zeros, ADD) otherwise.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (busy && !done) begin
        if (alu_op !== cur_alu_op) begin
          failures++;
          $display("FAIL alu_op_busy got=%b exp=%b t=%0t", alu_op, cur_alu_op, $time);
        end
      end else if (alu_op !== ALU_ADD || alu_a !== 32'h0 || alu_b !== 32'h0) begin
        failures++;
        $display("FAIL alu_idle got op=%b a=%h b=%h exp op=0000 a=0 b=0", alu_op, alu_a, alu_b);
      end
    end
  end

  function automatic exp_t model(logic o, logic [31:0] a, logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    e.dz = 1'b0;
    e.lat = 33;
    if (o == OP_MULTU) begin
      p = {32'h0, a} * {32'h0, b};
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == 32'h0) begin
      e.hi = a;
      e.lo = 32'hFFFF_FFFF;
      e.dz = 1'b1;
      e.lat = 1;
    end else begin
      e.hi = a % b;
      e.lo = a / b;
    end
    return e;
  endfunction

  task automatic issue(input logic o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    op = o;
    src_a = a;
    src_b = b;
    cur_alu_op = o ? ALU_SUB : ALU_ADD;
    exp_q.push_back(model(o, a, b));
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output bit seen);
    seen = 1'b0;
    cyc = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, div_zero} !== 3'b000 || hi !== 32'h0 || lo !== 32'h0 ||
        alu_a !== 32'h0 || alu_b !== 32'h0 || alu_op !== 4'b0000) begin
      failures++;
      $display("FAIL reset_values got busy=%b done=%b dz=%b hi=%h lo=%h a=%h b=%h op=%b exp all zero",
               busy, done, div_zero, hi, lo, alu_a, alu_b, alu_op);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_multu();
    logic [31:0] av[4] = '{32'd6, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0};
    logic [31:0] bv[4] = '{32'd7, 32'hFFFF_FFFF, 32'h9ABC_DEF0, 32'hDEAD_BEEF};
    int cyc; bit seen; exp_t e;
    for (int i = 0; i < 4; i++) begin
      issue(OP_MULTU, av[i], bv[i]);
      wait_done(cyc, seen);
      e = exp_q.pop_front();
      checks++;
      if (!seen || cyc != e.lat) begin
        failures++;
        $display("FAIL multu_latency[%0d] got=%0d seen=%0b exp=%0d", i, cyc, seen, e.lat);
      end
      checks++;
      if (hi !== e.hi || lo !== e.lo || div_zero !== e.dz) begin
        failures++;
        $display("FAIL multu_result[%0d] got hi=%h lo=%h dz=%b exp hi=%h lo=%h dz=%b",
                 i, hi, lo, div_zero, e.hi, e.lo, e.dz);
      end
    end
  endtask

  task automatic test_divu();
    logic [31:0] av[4] = '{32'd100, 32'h8000_0000, 32'hFFFF_FFFF, 32'd3};
    logic [31:0] bv[4] = '{32'd7, 32'd3, 32'h8000_0001, 32'd10};
    int cyc; bit seen; exp_t e;
    for (int i = 0; i < 4; i++) begin
      issue(OP_DIVU, av[i], bv[i]);
      wait_done(cyc, seen);
      e = exp_q.pop_front();
      checks++;
      if (!seen || cyc != e.lat) begin
        failures++;
        $display("FAIL divu_latency[%0d] got=%0d seen=%0b exp=%0d", i, cyc, seen, e.lat);
      end
      checks++;
      if (hi !== e.hi || lo !== e.lo || div_zero !== e.dz) begin
        failures++;
        $display("FAIL divu_result[%0d] got hi=%h lo=%h dz=%b exp hi=%h lo=%h dz=%b",
                 i, hi, lo, div_zero, e.hi, e.lo, e.dz);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (hi !== e.hi || lo !== e.lo || busy !== 1'b0) begin
      failures++;
      $display("FAIL divu_hold got hi=%h lo=%h busy=%b exp hi=%h lo=%h busy=0", hi, lo, busy, e.hi, e.lo);
    end
  endtask

  task automatic test_div_zero();
    int cyc; bit seen; exp_t e;
    issue(OP_DIVU, 32'd5, 32'd0);
    wait_done(cyc, seen);
    e = exp_q.pop_front();
    checks++;
    if (!seen || cyc != e.lat) begin
      failures++;
      $display("FAIL divzero_latency got=%0d seen=%0b exp=%0d", cyc, seen, e.lat);
    end
    checks++;
    if (hi !== e.hi || lo !== e.lo || div_zero !== e.dz) begin
      failures++;
      $display("FAIL divzero_result got hi=%h lo=%h dz=%b exp hi=%h lo=%h dz=%b",
               hi, lo, div_zero, e.hi, e.lo, e.dz);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (div_zero !== 1'b1) begin
      failures++;
      $display("FAIL divzero_sticky got=%b exp=1", div_zero);
    end
    issue(OP_MULTU, 32'd2, 32'd3);
    checks++;
    @(negedge clk);
    if (div_zero !== 1'b0) begin
      failures++;
      $display("FAIL divzero_clear got=%b exp=0", div_zero);
    end
    wait_done(cyc, seen);
    e = exp_q.pop_front();
    checks++;
    if (!seen || hi !== e.hi || lo !== e.lo || div_zero !== e.dz) begin
      failures++;
      $display("FAIL divzero_followup got seen=%0b hi=%h lo=%h dz=%b exp hi=%h lo=%h dz=%b",
               seen, hi, lo, div_zero, e.hi, e.lo, e.dz);
    end
  endtask

  task automatic test_start_ignored();
    int dones = 0; int done_cyc = 0; int busy_bad = 0; exp_t e;
    issue(OP_MULTU, 32'd6, 32'd7);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dones++;
        done_cyc = c;
        e = exp_q.pop_front();
        checks++;
        if (hi !== e.hi || lo !== e.lo || div_zero !== 1'b0) begin
          failures++;
          $display("FAIL ignored_result got hi=%h lo=%h dz=%b exp hi=%h lo=%h dz=0",
                   hi, lo, div_zero, e.hi, e.lo);
        end
      end
      if ((c <= 33) !== (busy === 1'b1)) busy_bad++;
      if (c == 5 || c == 20) begin
        start = 1'b1; op = OP_DIVU; src_a = 32'd99; src_b = 32'd0;
      end else begin
        start = 1'b0;
      end
    end
    checks++;
    if (dones != 1 || done_cyc != 33) begin
      failures++;
      $display("FAIL ignored_done_count got=%0d at=%0d exp=1 at=33", dones, done_cyc);
    end
    checks++;
    if (busy_bad != 0) begin
      failures++;
      $display("FAIL ignored_busy_window got bad_cycles=%0d exp=0", busy_bad);
    end
  endtask

  task automatic test_reset_mid_op();
    int cyc; bit seen; exp_t e;
    issue(OP_DIVU, 32'hCAFE_F00D, 32'd13);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, div_zero} !== 3'b000 || hi !== 32'h0 || lo !== 32'h0 ||
        alu_a !== 32'h0 || alu_b !== 32'h0 || alu_op !== 4'b0000) begin
      failures++;
      $display("FAIL midreset_values got busy=%b done=%b dz=%b hi=%h lo=%h a=%h b=%h op=%b exp all zero",
               busy, done, div_zero, hi, lo, alu_a, alu_b, alu_op);
    end
    rst_n = 1'b1;
    void'(exp_q.pop_back());
    wait_done(cyc, seen);
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL midreset_no_done got done at cycle %0d exp none", cyc);
    end
    issue(OP_DIVU, 32'd9, 32'd2);
    wait_done(cyc, seen);
    e = exp_q.pop_front();
    checks++;
    if (!seen || cyc != e.lat || hi !== e.hi || lo !== e.lo) begin
      failures++;
      $display("FAIL midreset_followup got seen=%0b cyc=%0d hi=%h lo=%h exp cyc=%0d hi=%h lo=%h",
               seen, cyc, hi, lo, e.lat, e.hi, e.lo);
    end
  endtask

  task automatic test_back_to_back();
    int cyc; bit seen; exp_t e; logic o; logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      o = i[0];
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'h0 : 32'($urandom >> $urandom_range(0, 24));
      issue(o, a, b);
      wait_done(cyc, seen);
      e = exp_q.pop_front();
      checks++;
      if (!seen || cyc != e.lat || hi !== e.hi || lo !== e.lo || div_zero !== e.dz) begin
        failures++;
        $display("FAIL b2b[%0d] op=%b a=%h b=%h got seen=%0b cyc=%0d hi=%h lo=%h dz=%b exp cyc=%0d hi=%h lo=%h dz=%b",
                 i, o, a, b, seen, cyc, hi, lo, div_zero, e.lat, e.hi, e.lo, e.dz);
      end
    end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_divu();
    test_div_zero();
    test_start_ignored();
    test_reset_mid_op();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
